// File: rtl/fp_mult_seq_if.sv
// Operand/result handshake bundle for the sequential floating-point multiplier.
// Valid/ready semantics on both channels: a transfer happens on a rising clk
// edge where valid && ready are both high; the sender holds its payload and
// valid stable until that edge, and ready may be low without conditions.
interface fp_mult_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  // Operand issuer / result consumer side.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  // Multiplier side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_mult_seq.sv
// Sequential IEEE-754-style multiplier with configurable field widths.
// Mantissas are multiplied one multiplier bit per cycle (shift-add), then the
// product is normalised, rounded to nearest-even and range-checked. Subnormal
// inputs are treated as zero and underflowing results flush to zero.
// Latency is fixed: special operands still walk the full multiply count.
module fp_mult_seq #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_mult_seq_if.slave      bus,
  output logic [2:0]        dbg_state
);

  localparam int N  = MAN_W + 1;          // significand width incl. hidden bit
  localparam int PW = 2 * N;              // full product width
  localparam int EW = EXP_W + 2;          // signed working exponent width
  localparam int CW = $clog2(N + 1);      // multiply step counter width

  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0]     ONES = '1;
  localparam logic [W-1:0]         QNAN = {1'b0, ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_NORM  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state;
  state_t state_nx;

  // Operand fields as seen on the input bus.
  logic [EXP_W-1:0] ea;
  logic [EXP_W-1:0] eb;
  logic [MAN_W-1:0] fa;
  logic [MAN_W-1:0] fb;

  // Captured operation context.
  logic                 sign;
  logic                 a_zero, a_inf, a_nan;
  logic                 b_zero, b_inf, b_nan;
  logic [N-1:0]         mcand;
  logic [N-1:0]         mplier;
  logic [PW-1:0]        prod;
  logic [CW-1:0]        cnt;
  logic signed [EW-1:0] exp_sum;

  // Normalised mantissa and rounding bits.
  logic [MAN_W-1:0]     frac_n;
  logic                 g_bit;
  logic                 r_bit;
  logic                 s_bit;

  // Registered outputs.
  logic [W-1:0]         result_r;
  logic [3:0]           flags_r;

  // Combinational helpers.
  logic [N:0]           acc_sum;
  logic [PW-2:0]        norm;
  logic                 rnd_inc;
  logic [MAN_W:0]       rnd_sum;
  logic signed [EW-1:0] exp_fin;
  logic [W-1:0]         res_nx;
  logic [3:0]           flg_nx;

  assign ea = bus.a[W-2:MAN_W];
  assign eb = bus.b[W-2:MAN_W];
  assign fa = bus.a[MAN_W-1:0];
  assign fb = bus.b[MAN_W-1:0];

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = result_r;
  assign bus.flags     = flags_r;
  assign dbg_state     = state;

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit is set; the carry-out becomes the new top bit.
  assign acc_sum = {1'b0, prod[PW-1:N]} + (mplier[0] ? {1'b0, mcand} : {(N+1){1'b0}});

  // Bring the leading one to bit PW-1 (dropped, it is the hidden bit).
  assign norm = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};

  // Round to nearest, ties to even; a carry out of the fraction bumps the exponent.
  assign rnd_inc = g_bit & (r_bit | s_bit | frac_n[0]);
  assign rnd_sum = {1'b0, frac_n} + {{MAN_W{1'b0}}, rnd_inc};
  assign exp_fin = exp_sum + $signed({{(EW-1){1'b0}}, rnd_sum[MAN_W]});

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state sequencing through the fixed-latency pipeline of phases.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.in_valid) state_nx = S_MUL;
      S_MUL:   if (cnt == CW'(N - 1)) state_nx = S_NORM;
      S_NORM:  state_nx = S_ROUND;
      S_ROUND: state_nx = S_DONE;
      S_DONE:  if (bus.out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Result selection: special operands first, then range checks on the
  // rounded exponent, otherwise the rounded normal number.
  always_comb begin
    res_nx = '0;
    flg_nx = 4'b0000;
    if (a_nan || b_nan) begin
      res_nx = QNAN;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      res_nx = QNAN;
      flg_nx = 4'b1000;
    end else if (a_inf || b_inf) begin
      res_nx = {sign, ONES, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      res_nx = {sign, {(W-1){1'b0}}};
    end else if (!exp_fin[EW-1] && (exp_fin >= EMAX)) begin
      res_nx = {sign, ONES, {MAN_W{1'b0}}};
      flg_nx = 4'b0101;
    end else if (exp_fin[EW-1] || (exp_fin == '0)) begin
      res_nx = {sign, {(W-1){1'b0}}};
      flg_nx = 4'b0011;
    end else begin
      res_nx = {sign, exp_fin[EXP_W-1:0], rnd_sum[MAN_W-1:0]};
      flg_nx = {3'b000, g_bit | r_bit | s_bit};
    end
  end

  // Datapath registers advanced according to the current phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign     <= 1'b0;
      a_zero   <= 1'b0;
      a_inf    <= 1'b0;
      a_nan    <= 1'b0;
      b_zero   <= 1'b0;
      b_inf    <= 1'b0;
      b_nan    <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      cnt      <= '0;
      exp_sum  <= '0;
      frac_n   <= '0;
      g_bit    <= 1'b0;
      r_bit    <= 1'b0;
      s_bit    <= 1'b0;
      result_r <= '0;
      flags_r  <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            sign    <= bus.a[W-1] ^ bus.b[W-1];
            a_zero  <= (ea == '0);
            a_inf   <= (ea == ONES) && (fa == '0);
            a_nan   <= (ea == ONES) && (fa != '0);
            b_zero  <= (eb == '0);
            b_inf   <= (eb == ONES) && (fb == '0);
            b_nan   <= (eb == ONES) && (fb != '0);
            mcand   <= {1'b1, fa};
            mplier  <= {1'b1, fb};
            prod    <= '0;
            cnt     <= '0;
            exp_sum <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
            flags_r <= 4'b0000;
          end
        end
        S_MUL: begin
          prod   <= {acc_sum, prod[N-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        S_NORM: begin
          frac_n <= norm[PW-2 -: MAN_W];
          g_bit  <= norm[N-1];
          r_bit  <= norm[N-2];
          s_bit  <= |norm[N-3:0];
          if (prod[PW-1]) exp_sum <= exp_sum + EW'(1);
        end
        S_ROUND: begin
          result_r <= res_nx;
          flags_r  <= flg_nx;
        end
        default: ;
      endcase
    end
  end

endmodule
